// File: rtl/fxp_addmul_pipe.sv
// Pipelined signed fixed-point Y = (A +/- B) * C with valid tracking and clock-enable stall.
// Define FXP_ADDMUL_SAT_EN to add a third stage producing a rounded, saturated y_sat and ovf.
module fxp_addmul_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    sub,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    output logic signed [WIDTH:0]   sum_res,
    output logic                    out_valid,
`ifdef FXP_ADDMUL_SAT_EN
    output logic signed [2*WIDTH:0] y,
    output logic signed [WIDTH-1:0] y_sat,
    output logic                    ovf
`else
    output logic signed [2*WIDTH:0] y
`endif
);

    localparam int unsigned PW = 2 * WIDTH + 1;

    logic signed [WIDTH:0]   a_ext, b_ext, sum_d, sum_q;
    logic signed [WIDTH-1:0] c_q;
    logic                    v1_q, v2_q;
    logic signed [PW-1:0]    sum_wide, c_wide, prod_d, prod_q;

    always_comb begin
        a_ext = {a[WIDTH-1], a};
        b_ext = {b[WIDTH-1], b};
        sum_d = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    end

    // Operands widened to the product width so the multiply is exact.
    always_comb begin
        sum_wide = {{(PW-WIDTH-1){sum_q[WIDTH]}}, sum_q};
        c_wide   = {{(PW-WIDTH){c_q[WIDTH-1]}}, c_q};
        prod_d   = sum_wide * c_wide;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            c_q    <= '0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
        end else if (ce) begin
            sum_q  <= sum_d;
            c_q    <= c;
            v1_q   <= in_valid;
            prod_q <= prod_d;
            v2_q   <= v1_q;
        end
    end

    assign sum_res = sum_q;

`ifdef FXP_ADDMUL_SAT_EN
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [PW:0] RND_BIAS = (PW+1)'(1 << (FRAC - 1));

    logic signed [PW:0]      rnd, r;
    logic signed [WIDTH-1:0] sat_d, sat_q;
    logic                    ovf_d, ovf_q, v3_q;
    logic signed [PW-1:0]    y3_q;

    // One extra bit keeps the rounding bias from overflowing at the positive extreme.
    always_comb begin
        rnd   = {prod_q[PW-1], prod_q} + RND_BIAS;
        r     = rnd >>> FRAC;
        sat_d = r[WIDTH-1:0];
        ovf_d = 1'b0;
        if (r > SAT_MAX) begin
            sat_d = SAT_MAX[WIDTH-1:0];
            ovf_d = 1'b1;
        end else if (r < SAT_MIN) begin
            sat_d = SAT_MIN[WIDTH-1:0];
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= '0;
            ovf_q <= 1'b0;
            y3_q  <= '0;
            v3_q  <= 1'b0;
        end else if (ce) begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            y3_q  <= prod_q;
            v3_q  <= v2_q;
        end
    end

    assign y         = y3_q;
    assign y_sat     = sat_q;
    assign ovf       = ovf_q;
    assign out_valid = v3_q;
`else
    assign y         = prod_q;
    assign out_valid = v2_q;
`endif

endmodule

// File: tb/tb_fxp_addmul_pipe.sv
// Self-checking bench for fxp_addmul_pipe: directed table, ce stalls, async reset, random stream.
// Follows FXP_ADDMUL_SAT_EN to pick latency and the y_sat/ovf checks.
module tb_fxp_addmul_pipe;

    localparam int W = 8;
    localparam int F = 6;
`ifdef FXP_ADDMUL_SAT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic           clk = 1'b0;
    logic           rst, ce, in_valid, sub;
    logic [W-1:0]   a, b, c;
    logic [W:0]     sum_res;
    logic           out_valid;
    logic [2*W:0]   y;
    logic [W-1:0]   y_sat;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fxp_addmul_pipe #(.WIDTH(W), .FRAC(F)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .in_valid (in_valid),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c        (c),
        .sum_res  (sum_res),
        .out_valid(out_valid),
`ifdef FXP_ADDMUL_SAT_EN
        .y        (y),
        .y_sat    (y_sat),
        .ovf      (ovf)
`else
        .y        (y)
`endif
    );
`ifndef FXP_ADDMUL_SAT_EN
    assign y_sat = '0;
    assign ovf   = 1'b0;
`endif

    typedef struct {
        bit     v;
        longint sum;
        longint prod;
    } ent_t;
    ent_t hist[$];

    typedef struct {
        logic [W-1:0] a, b, c;
        bit           s;
        logic [W:0]   e_sum;
        logic [2*W:0] e_y;
        logic [W-1:0] e_sat;
        bit           e_ovf;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Round half toward +inf, then clamp to the narrow signed range.
    function automatic longint sat_of(input longint p, output bit o);
        longint r, hi, lo;
        r  = (p + (64'sd1 <<< (F - 1))) >>> F;
        hi = (64'sd1 <<< (W - 1)) - 1;
        lo = -(64'sd1 <<< (W - 1));
        o  = (r > hi) || (r < lo);
        return (r > hi) ? hi : (r < lo) ? lo : r;
    endfunction

    task automatic check_model();
        bit     ev, o;
        longint s;
        ev = (hist.size() >= LAT) ? hist[LAT-1].v : 1'b0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("sum_res", 64'(sum_res),
            (hist.size() > 0) ? 64'(hist[0].sum & 64'h1FF) : 64'd0);
        if (ev) begin
            chk("y", 64'(y), 64'(hist[LAT-1].prod & 64'h1FFFF));
`ifdef FXP_ADDMUL_SAT_EN
            s = sat_of(hist[LAT-1].prod, o);
            chk("y_sat", 64'(y_sat), 64'(s & 64'hFF));
            chk("ovf", 64'(ovf), 64'(o));
`endif
        end
    endtask

    task automatic step(input bit ce_v, input bit v, input bit s,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv);
        ent_t e;
        ce = ce_v; in_valid = v; sub = s; a = av; b = bv; c = cv;
        @(posedge clk);
        #1;
        if (ce_v) begin
            e.v    = v;
            e.sum  = s ? (sx(av) - sx(bv)) : (sx(av) + sx(bv));
            e.prod = e.sum * sx(cv);
            hist.push_front(e);
            if (hist.size() > 8) void'(hist.pop_back());
        end
        check_model();
    endtask

    initial begin
        tbl[0] = '{8'h81, 8'h82, 8'h58, 1'b0, 9'h103, 17'h1A908, 8'h80, 1'b1};
        tbl[1] = '{8'h10, 8'h08, 8'h20, 1'b0, 9'h018, 17'h00300, 8'h0C, 1'b0};
        tbl[2] = '{8'h20, 8'h30, 8'h40, 1'b1, 9'h1F0, 17'h1FC00, 8'hF0, 1'b0};
        tbl[3] = '{8'h7F, 8'h7F, 8'h7F, 1'b0, 9'h0FE, 17'h07E02, 8'h7F, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 8'h80, 1'b0, 9'h100, 17'h08000, 8'h7F, 1'b1};

        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_sum_res", 64'(sum_res), 64'd0);
        chk("reset_y_sat", 64'(y_sat), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, back to back, then flushed with bubbles.
        for (int i = 0; i < 5 + LAT; i++) begin
            int j;
            if (i < 5) step(1'b1, 1'b1, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c);
            else       step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            if (i < 5) chk("tbl_sum_res", 64'(sum_res), 64'(tbl[i].e_sum));
            j = i - LAT + 1;
            if (j >= 0 && j < 5) begin
                chk("tbl_out_valid", 64'(out_valid), 64'd1);
                chk("tbl_y", 64'(y), 64'(tbl[j].e_y));
`ifdef FXP_ADDMUL_SAT_EN
                chk("tbl_y_sat", 64'(y_sat), 64'(tbl[j].e_sat));
                chk("tbl_ovf", 64'(ovf), 64'(tbl[j].e_ovf));
`endif
            end
        end

        // Stall for 4 cycles with the pipe full; inputs change while frozen.
        step(1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        step(1'b1, 1'b1, 1'b1, 8'h44, 8'h15, 8'hC6);
        begin
            logic [2*W:0] y_hold;
            logic [W:0]   s_hold;
            y_hold = y; s_hold = sum_res;
            repeat (4) begin
                step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
                chk("stall_y_hold", 64'(y), 64'(y_hold));
                chk("stall_sum_hold", 64'(sum_res), 64'(s_hold));
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h7A, 8'h91, 8'h05);
        repeat (LAT) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Async reset with two samples in flight.
        step(1'b1, 1'b1, 1'b0, 8'h30, 8'h30, 8'h40);
        step(1'b1, 1'b1, 1'b0, 8'h81, 8'h82, 8'h58);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_y", 64'(y), 64'd0);
        chk("arst_sum_res", 64'(sum_res), 64'd0);
        chk("arst_y_sat", 64'(y_sat), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        hist.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) step(1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 8'h77);
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h08, 8'h20);
        repeat (LAT) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Random stream with occasional stalls against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fxp_addmul_pipe.md
# fxp_addmul_pipe

Parametrised, pipelined signed fixed-point add/subtract-then-multiply unit computing Y = (A ± B) · C. It is the next-generation replacement for the fixed 8-bit summator in the arithmetic datapath: generic width and fraction point, valid tracking through the pipe, clock-enable stall and an optional rounded/saturated narrow output.

## Interface
- WIDTH, 8, operand width (signed two's complement), ≥ 4
- FRAC, 6, fraction bits of a/b/c, 1 ≤ FRAC ≤ WIDTH-2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; 0 freezes every pipeline register including valids
- in_valid  in  1  a/b/c/sub qualify this cycle (sampled only when ce=1)
- sub  in  1  0: a+b, 1: a−b
- a, b, c  in  WIDTH  signed operands, FRAC fraction bits
- sum_res  out  WIDTH+1  registered stage-1 sum/difference, FRAC fraction bits
- out_valid  out  1  y (and y_sat/ovf when enabled) valid
- y  out  2·WIDTH+1  full-precision product, 2·FRAC fraction bits
- y_sat  out  WIDTH  rounded, saturated result, FRAC fraction bits (macro only)
- ovf  out  1  y_sat was clamped (macro only)

## Operation
- Stage 1 (ce=1): sum_res ← sext(a) ± sext(b) in WIDTH+1 bits (never overflows); c delayed one stage; v1 ← in_valid.
- Stage 2 (ce=1): y ← signed(sum_res) · signed(c_d), exact in 2·WIDTH+1 bits; v2 ← v1.
- Stage 3 (macro only, ce=1): r = (y + 2^(FRAC−1)) >>> FRAC (round half toward +inf); y_sat ← clamp(r, −2^(WIDTH−1), 2^(WIDTH−1)−1); ovf ← 1 iff clamped; v3 ← v2.
- out_valid = last-stage valid. Data registers load every ce=1 cycle regardless of valid; consumers qualify with out_valid.
- Bubbles (in_valid=0) propagate as out_valid=0; no reordering, no drops while ce=1.
- ce=0: all registers hold, including out_valid; downstream sees the same output repeatedly and must count on its own ce.
- Reset: all data registers, sum_res, y, y_sat, ovf, all valids → 0, immediately on rst assertion; in-flight data discarded.

## Timing
- Latency in_valid → out_valid: 2 ce-cycles (3 with macro). sum_res visible 1 ce-cycle after sampling.
- Throughput: one result per ce-cycle, fully pipelined.
- First sample after rst deasserts: clk edge where rst=0, ce=1.
- rst asserted mid-stream: outputs 0 at once; no partial result emerges after release.
- Extreme: a=b=−2^(WIDTH−1), sub=0, c=−2^(WIDTH−1) → y=+2^(2·WIDTH−1), representable; y_sat saturates positive, ovf=1.

## Configuration
- FXP_ADDMUL_SAT_EN defined: stage 3 present, y_sat/ovf ports exist, latency 3; y is delayed to stage 3 so y, y_sat, ovf align with out_valid.
- Undefined: no y_sat/ovf ports, latency 2, y from stage 2.

## Test plan
(WIDTH=8, FRAC=6, ce=1 unless stated, macro defined)
- a=0x81, b=0x82, c=0x58, sub=0 -> sum_res=9'h103 after 1 cycle; y=17'h1A908, y_sat=0x80, ovf=1, out_valid=1 after 3 cycles.
- a=0x10, b=0x08, c=0x20 -> y=17'h00300, y_sat=0x0C, ovf=0.
- sub=1, a=0x20, b=0x30, c=0x40 -> sum_res=9'h1F0, y=17'h1FC00, y_sat=0xF0, ovf=0.
- a=b=c=0x7F -> y=17'h07E02, y_sat=0x7F, ovf=1; back-to-back with previous vectors → one result per cycle, in order.
- Valid stream with ce=0 for 4 cycles mid-pipe -> outputs and out_valid frozen; resumes with correct results, none lost or duplicated once ce=1.
- rst pulsed with two samples in flight -> y, y_sat, ovf, sum_res, out_valid = 0 asynchronously; no out_valid until new input + 3 cycles. Rerun with macro undefined: latency 2, y identical.
